// File: rtl/apb_pkg.sv
// Shared types for the N-slave APB4 requester bridge.
package apb_pkg;

  localparam int PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR
  } apb_state_t;

  typedef struct packed {
    logic valid;
    logic err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Slave decode: index field of the address -> one-hot select and in-range flag.
module apb_addr_decoder #(
  parameter  int AW      = 32,
  parameter  int NSLV    = 2,
  parameter  int SLV_LSB = 12,
  localparam int SW      = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [AW-1:0]   addr,
  output logic [NSLV-1:0] sel,
  output logic [SW-1:0]   idx,
  output logic            hit
);

  logic unused_addr;

  assign idx         = addr[SLV_LSB +: SW];
  assign hit         = (int'(idx) < NSLV);
  assign unused_addr = ^addr;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      sel[i] = hit && (idx == SW'(i));
    end
  end

endmodule

// File: rtl/apb_bridge_nslv.sv
// APB4 requester bridge: valid/ready request in, IDLE->SETUP->ACCESS on one of
// NSLV slaves, one-cycle response out. Decode errors and ACCESS timeouts respond with err.
module apb_bridge_nslv
  import apb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 2,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW-1:0]      req_addr,
  input  logic               req_write,
  input  logic [DW-1:0]      req_wdata,
  input  logic [DW/8-1:0]    req_strb,
  input  logic [PROT_W-1:0]  req_prot,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [NSLV-1:0]    psel,
  output logic               penable,
  output logic [AW-1:0]      paddr,
  output logic               pwrite,
  output logic [DW-1:0]      pwdata,
  output logic [DW/8-1:0]    pstrb,
  output logic [PROT_W-1:0]  pprot,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pslverr
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = (TW > 0) ? TW : 1;
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT);

  apb_state_t     state;
  apb_rsp_t       rsp_q;
  logic [SW-1:0]  idx_q;
  logic [CW-1:0]  cnt;

  logic [NSLV-1:0] dec_sel;
  logic [SW-1:0]   dec_idx;
  logic            dec_hit;

  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;
  logic            timed_out;

  apb_addr_decoder #(
    .AW      (AW),
    .NSLV    (NSLV),
    .SLV_LSB (SLV_LSB)
  ) u_dec (
    .addr (req_addr),
    .sel  (dec_sel),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  assign req_ready = (state == IDLE) && !rsp_q.valid;
  assign rsp_valid = rsp_q.valid;
  assign rsp_err   = rsp_q.err;

  // Only the latched target's handshake signals are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (idx_q == SW'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DW +: DW];
      end
    end
  end

  assign timed_out = (TIMEOUT != 0) && (({1'b0, cnt} + 1'b1) >= TO_LIM);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      rsp_q     <= '0;
      rsp_rdata <= '0;
      idx_q     <= '0;
      cnt       <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
    end else begin
      rsp_q     <= '0;
      rsp_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            paddr  <= req_addr;
            pwrite <= req_write;
            pwdata <= req_wdata;
            pstrb  <= req_write ? req_strb : '0;
            pprot  <= req_prot;
            idx_q  <= dec_idx;
            if (dec_hit) begin
              psel  <= dec_sel;
              cnt   <= '0;
              state <= SETUP;
            end else begin
              rsp_q <= '{valid: 1'b1, err: 1'b1};
              state <= DECERR;
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_q     <= '{valid: 1'b1, err: sel_err};
            rsp_rdata <= pwrite ? '0 : sel_rdata;
            state     <= IDLE;
          end else if (timed_out) begin
            psel    <= '0;
            penable <= 1'b0;
            rsp_q   <= '{valid: 1'b1, err: 1'b1};
            state   <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        DECERR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// Self-checking bench for apb_bridge_nslv with a cycle-level transfer model.
module tb_apb_bridge_nslv;

  localparam int NS  = 3;
  localparam int TO  = 4;

  logic          clk = 1'b0;
  logic          presetn;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic [3:0]    req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [NS-1:0] psel;
  logic          penable;
  logic [31:0]   paddr;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [NS-1:0] pready  = '0;
  logic [NS*32-1:0] prdata = '0;
  logic [NS-1:0] pslverr = '0;

  int checks = 0;
  int errors = 0;

  int unsigned wait_cfg [NS];
  logic [31:0] rdata_cfg[NS];
  logic        err_cfg  [NS];
  int unsigned acnt     [NS];
  bit          noise = 1'b0;

  apb_bridge_nslv #(
    .AW      (32),
    .DW      (32),
    .NSLV    (NS),
    .SLV_LSB (12),
    .TIMEOUT (TO)
  ) dut (
    .pclk      (clk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  // Slave responders: wait_cfg[i] ACCESS cycles of pready=0, then ready; noise elsewhere.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (psel[i] && penable) begin
        pready[i] = (acnt[i] >= wait_cfg[i]);
        acnt[i]   = acnt[i] + 1;
        pslverr[i] = err_cfg[i];
        prdata[i*32 +: 32] = rdata_cfg[i];
      end else begin
        acnt[i]    = 0;
        pready[i]  = noise ? 1'($urandom) : 1'b0;
        pslverr[i] = noise ? 1'($urandom) : err_cfg[i];
        prdata[i*32 +: 32] = noise ? $urandom : rdata_cfg[i];
      end
    end
  end

  task automatic set_slave(input int s, input int unsigned w, input logic [31:0] rd, input logic e);
    wait_cfg[s]  = w;
    rdata_cfg[s] = rd;
    err_cfg[s]   = e;
  endtask

  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input string tag);
    int unsigned idx, lat, k;
    logic          dec, exp_err;
    logic [31:0]   exp_rd;
    logic [NS-1:0] exp_sel;
    logic [77:0]   obs, exp;
    idx = (addr >> 12) & 3;
    dec = (idx >= NS);
    exp_sel = '0;
    if (dec) begin
      lat = 1; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_sel = NS'(1) << idx;
      if (wait_cfg[idx] < TO) begin
        lat = 3 + wait_cfg[idx]; exp_err = err_cfg[idx]; exp_rd = wr ? 32'h0 : rdata_cfg[idx];
      end else begin
        lat = 2 + TO; exp_err = 1'b1; exp_rd = '0;
      end
    end
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_req: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_strb = st; req_prot = pr;
    @(posedge clk);
    #1;
    // Keep valid high with junk while busy; it must be ignored.
    req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
    req_strb = 4'($urandom); req_prot = 3'($urandom);
    for (int unsigned c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c < lat) begin
        exp = {exp_sel, 1'(c >= 2), addr, wr, wd, (wr ? st : 4'h0), pr, 1'b0, 1'b0};
        obs = {psel, penable, paddr, pwrite, pwdata, pstrb, pprot, rsp_valid, req_ready};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s apb_bus c=%0d: got %h want %h", tag, c, obs, exp);
        end
      end else if (c == lat) begin
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, psel, penable, req_ready} !==
            {1'b1, exp_err, exp_rd, {NS{1'b0}}, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s response c=%0d: got v=%b e=%b d=%h sel=%b en=%b rdy=%b want v=1 e=%b d=%h sel=0 en=0 rdy=0",
                   tag, c, rsp_valid, rsp_err, rsp_rdata, psel, penable, req_ready, exp_err, exp_rd);
        end
      end else begin
        checks++;
        if ({rsp_valid, req_ready, psel} !== {1'b0, 1'b1, {NS{1'b0}}}) begin
          errors++;
          $display("FAIL %s after_rsp: got v=%b rdy=%b sel=%b want v=0 rdy=1 sel=0",
                   tag, rsp_valid, req_ready, psel);
        end
      end
    end
  endtask

  task automatic test_reset();
    presetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    for (int i = 0; i < NS; i++) set_slave(i, 0, 32'h0, 1'b0);
    #3;
    checks++;
    if ({psel, penable, paddr, pwrite, pwdata, pstrb, pprot} !== '0) begin
      errors++;
      $display("FAIL reset_apb: got sel=%b en=%b addr=%h w=%b wd=%h st=%h pr=%h want all 0",
               psel, penable, paddr, pwrite, pwdata, pstrb, pprot);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b e=%b d=%h rdy=%b want v=0 e=0 d=0 rdy=1",
               rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    repeat (2) @(negedge clk);
    presetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    set_slave(1, 0, 32'hAAAA_5555, 1'b0);
    do_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'h0, "write_basic");
  endtask

  task automatic test_read_wait();
    set_slave(0, 2, 32'h1234_5678, 1'b0);
    do_xfer(32'h0000_0010, 1'b0, 32'hCAFE_F00D, 4'hF, 3'h2, "read_wait");
  endtask

  task automatic test_decode_err();
    do_xfer(32'h0000_3000, 1'b0, 32'h0, 4'h0, 3'h0, "decode_err");
  endtask

  task automatic test_timeout();
    set_slave(1, 99, 32'h7777_7777, 1'b0);
    do_xfer(32'h0000_1ABC, 1'b0, 32'h0, 4'h0, 3'h5, "timeout");
    set_slave(2, TO - 1, 32'h0BAD_CAFE, 1'b0);
    do_xfer(32'h0000_2040, 1'b0, 32'h0, 4'h0, 3'h1, "last_wait_before_timeout");
  endtask

  task automatic test_back_to_back();
    set_slave(0, 0, 32'h0, 1'b1);
    set_slave(2, 1, 32'h5A5A_A5A5, 1'b0);
    do_xfer(32'h0000_0100, 1'b1, 32'h0102_0304, 4'h5, 3'h3, "slverr_write");
    do_xfer(32'h0000_2008, 1'b0, 32'h0, 4'h0, 3'h0, "b2b_read");
  endtask

  task automatic test_reset_mid();
    set_slave(0, 99, 32'h1111_2222, 1'b0);
    req_valid = 1'b1; req_addr = 32'h0000_0020; req_write = 1'b0; req_strb = 4'h0; req_prot = 3'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({psel, penable} !== {3'b001, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_pre: got sel=%b en=%b want sel=001 en=1", psel, penable);
    end
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, paddr, rsp_valid, req_ready} !== {3'b000, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_drop: got sel=%b en=%b addr=%h v=%b rdy=%b want 0 0 0 0 rdy=1",
               psel, penable, paddr, rsp_valid, req_ready);
    end
    @(negedge clk);
    presetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, psel, req_ready} !== {1'b0, 3'b000, 1'b1}) begin
        errors++;
        $display("FAIL reset_mid_quiet c=%0d: got v=%b sel=%b rdy=%b want v=0 sel=0 rdy=1",
                 c, rsp_valid, psel, req_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    noise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NS; i++) set_slave(i, $urandom_range(0, 5), $urandom, 1'($urandom));
      a = $urandom;
      a[13:12] = 2'($urandom_range(0, 3));
      do_xfer(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), "random");
    end
    noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_decode_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
